// File: rtl/present_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : present_core
// Description : Iterative PRESENT cipher, one round per clock, encrypt and
//               decrypt, 80/128-bit keys, on-the-fly key schedule both ways.
//               Optional decrypt-key cache: define PRESENT_KEY_CACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module present_core #(
    parameter int KEY_SIZE = 80,
    parameter int ROUNDS   = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_mode,
    input  logic [KEY_SIZE-1:0] i_key_in,
    input  logic [63:0]         i_data_in,
    output logic                o_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic [63:0]         o_data_out
);

    localparam int          c_XOR_LSB  = (KEY_SIZE == 128) ? 62 : 15;
    localparam logic [4:0]  c_LAST     = 5'(ROUNDS);
    localparam logic [63:0] c_SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] c_INV_SBOX = 64'hA970364BD21C8FE5;

    generate
        if (KEY_SIZE != 80 && KEY_SIZE != 128) begin : g_bad_key_size
            $error("present_core: KEY_SIZE must be 80 or 128");
        end
        if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
            $error("present_core: ROUNDS must be in 1..31");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_ENC   = 3'd2,
        S_DEC   = 3'd3,
        S_FINAL = 3'd4
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return c_SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return c_INV_SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) r[6'(n*4) +: 4] = sbox(s[6'(n*4) +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] inv_s_layer(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) r[6'(n*4) +: 4] = inv_sbox(s[6'(n*4) +: 4]);
        return r;
    endfunction

    // Bit b moves to b*16 mod 63; bit 63 is fixed.
    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 63; b++) r[6'((b*16) % 63)] = s[6'(b)];
        r[63] = s[63];
        return r;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 63; b++) r[6'(b)] = s[6'((b*16) % 63)];
        r[63] = s[63];
        return r;
    endfunction

    function automatic logic [KEY_SIZE-1:0] key_fwd(input logic [KEY_SIZE-1:0] k,
                                                    input logic [4:0] rc);
        logic [KEY_SIZE-1:0] t;
        t = {k[KEY_SIZE-62:0], k[KEY_SIZE-1:KEY_SIZE-61]};
        t[KEY_SIZE-1 -: 4] = sbox(t[KEY_SIZE-1 -: 4]);
        if (KEY_SIZE == 128) t[KEY_SIZE-5 -: 4] = sbox(t[KEY_SIZE-5 -: 4]);
        t[c_XOR_LSB +: 5] = t[c_XOR_LSB +: 5] ^ rc;
        return t;
    endfunction

    function automatic logic [KEY_SIZE-1:0] key_inv(input logic [KEY_SIZE-1:0] k,
                                                    input logic [4:0] rc);
        logic [KEY_SIZE-1:0] t;
        t = k;
        t[c_XOR_LSB +: 5] = t[c_XOR_LSB +: 5] ^ rc;
        t[KEY_SIZE-1 -: 4] = inv_sbox(t[KEY_SIZE-1 -: 4]);
        if (KEY_SIZE == 128) t[KEY_SIZE-5 -: 4] = inv_sbox(t[KEY_SIZE-5 -: 4]);
        return {t[60:0], t[KEY_SIZE-1:61]};
    endfunction

    state_t              r_fsm;
    state_t              w_fsm_next;
    logic [63:0]         r_state;
    logic [KEY_SIZE-1:0] r_key;
    logic [4:0]          r_round;
    logic [63:0]         r_data_out;
    logic                r_done;

    logic [63:0]         w_round_key;
    logic [63:0]         w_enc_state;
    logic [63:0]         w_dec_state;
    logic [KEY_SIZE-1:0] w_key_fwd;
    logic [KEY_SIZE-1:0] w_key_inv;
    logic                w_accept;
    logic                w_hit;
    logic [KEY_SIZE-1:0] w_hit_key;

    assign w_round_key = r_key[KEY_SIZE-1 -: 64];
    assign w_enc_state = p_layer(s_layer(r_state ^ w_round_key));
    assign w_dec_state = inv_s_layer(inv_p_layer(r_state ^ w_round_key));
    assign w_key_fwd   = key_fwd(r_key, r_round);
    assign w_key_inv   = key_inv(r_key, r_round);
    assign w_accept    = (r_fsm == S_IDLE) && i_start;

`ifdef PRESENT_KEY_CACHE_EN
    logic [KEY_SIZE-1:0] r_user_key;
    logic [KEY_SIZE-1:0] r_cache_key;
    logic [KEY_SIZE-1:0] r_cache_klast;
    logic                r_cache_valid;

    assign w_hit     = i_mode && r_cache_valid && (i_key_in == r_cache_key);
    assign w_hit_key = r_cache_klast;

    // The last forward update of ENC or PREP produces K(ROUNDS+1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_user_key    <= '0;
            r_cache_key   <= '0;
            r_cache_klast <= '0;
            r_cache_valid <= 1'b0;
        end else begin
            if (w_accept) r_user_key <= i_key_in;
            if ((r_fsm == S_ENC || r_fsm == S_PREP) && r_round == c_LAST) begin
                r_cache_key   <= r_user_key;
                r_cache_klast <= w_key_fwd;
                r_cache_valid <= 1'b1;
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_key = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_IDLE:  if (i_start) w_fsm_next = w_hit ? S_DEC : (i_mode ? S_PREP : S_ENC);
            S_PREP:  if (r_round == c_LAST) w_fsm_next = S_DEC;
            S_ENC:   if (r_round == c_LAST) w_fsm_next = S_FINAL;
            S_DEC:   if (r_round == 5'd1)   w_fsm_next = S_FINAL;
            S_FINAL: w_fsm_next = S_IDLE;
            default: w_fsm_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= '0;
            r_key      <= '0;
            r_round    <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= i_data_in;
                        r_key   <= w_hit ? w_hit_key : i_key_in;
                        r_round <= w_hit ? c_LAST : 5'd1;
                    end
                end
                S_PREP: begin
                    r_key   <= w_key_fwd;
                    r_round <= (r_round == c_LAST) ? r_round : r_round + 5'd1;
                end
                S_ENC: begin
                    r_state <= w_enc_state;
                    r_key   <= w_key_fwd;
                    r_round <= r_round + 5'd1;
                end
                S_DEC: begin
                    r_state <= w_dec_state;
                    r_key   <= w_key_inv;
                    r_round <= r_round - 5'd1;
                end
                S_FINAL: begin
                    r_data_out <= r_state ^ w_round_key;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_ready    = (r_fsm == S_IDLE);
    assign o_busy     = ~o_ready;
    assign o_done     = r_done;
    assign o_data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_present_core.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for present_core: 80-bit and 128-bit instances, published
// PRESENT vectors, latency, reset abort, cache and back-to-back behaviour.
module tb_present_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         s80, m80, r80, b80, dn80;
    logic [79:0]  k80;
    logic [63:0]  d80, q80;
    logic         s128, m128, r128, b128, dn128;
    logic [127:0] k128;
    logic [63:0]  d128, q128;

    present_core #(.KEY_SIZE(80), .ROUNDS(31)) dut80 (
        .clk(clk), .rst_n(rst_n), .i_start(s80), .i_mode(m80),
        .i_key_in(k80), .i_data_in(d80), .o_ready(r80), .o_busy(b80),
        .o_done(dn80), .o_data_out(q80)
    );

    present_core #(.KEY_SIZE(128), .ROUNDS(31)) dut128 (
        .clk(clk), .rst_n(rst_n), .i_start(s128), .i_mode(m128),
        .i_key_in(k128), .i_data_in(d128), .o_ready(r128), .o_busy(b128),
        .o_done(dn128), .o_data_out(q128)
    );

`ifdef PRESENT_KEY_CACHE_EN
    localparam int HIT_LAT = 32;
`else
    localparam int HIT_LAT = 63;
`endif

    localparam logic [127:0] ONES = '1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          sel;
        logic [63:0] data;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    function automatic logic get_ready(input bit sel);
        return sel ? r128 : r80;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? b128 : b80;
    endfunction
    function automatic logic get_done(input bit sel);
        return sel ? dn128 : dn80;
    endfunction
    function automatic logic [63:0] get_data(input bit sel);
        return sel ? q128 : q80;
    endfunction

    task automatic drive(input bit sel, input logic st, input logic m,
                         input logic [127:0] k, input logic [63:0] d);
        if (sel) begin s128 = st; m128 = m; k128 = k;      d128 = d; end
        else     begin s80  = st; m80  = m; k80  = k[79:0]; d80 = d; end
    endtask

    task automatic push_exp(input bit sel, input logic [63:0] exp, input int lat);
        exp_t e;
        e.sel = sel; e.data = exp; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
    endtask

    // Waits for ready, accepts one operation with a single-cycle start.
    task automatic issue(input bit sel, input logic m, input logic [127:0] k,
                         input logic [63:0] d, input logic [63:0] exp,
                         input int lat, input bit push);
        int n;
        n = 0;
        while (!get_ready(sel) && n < 200) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (!get_ready(sel)) begin
            n_fail++;
            $display("FAIL ready_wait: ready=0 required 1");
        end
        drive(sel, 1'b1, m, k, d);
        @(posedge clk); #1;
        drive(sel, 1'b0, m, k, d);
        if (push) push_exp(sel, exp, lat);
    endtask

    // Pops the oldest expectation and compares it against the next done pulse.
    task automatic sb_collect(input string name);
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        while (!get_done(e.sel) && n < 200) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (!get_done(e.sel)) begin
            n_fail++;
            $display("FAIL %s_timeout: done=0 required 1", name);
        end else begin
            n_checks++;
            if (get_data(e.sel) !== e.data) begin
                n_fail++;
                $display("FAIL %s_data: got %h required %h", name, get_data(e.sel), e.data);
            end
            n_checks++;
            if (cyc - e.acc != e.lat) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d required %0d", name, cyc - e.acc, e.lat);
            end
            n_checks++;
            if (get_ready(e.sel) !== 1'b1 || get_busy(e.sel) !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_ready_at_done: ready=%b busy=%b required 1/0",
                         name, get_ready(e.sel), get_busy(e.sel));
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        pulse_reset();
        n_checks += 8;
        if (r80 !== 1'b1)    begin n_fail++; $display("FAIL rst_ready80: got %b required 1", r80); end
        if (b80 !== 1'b0)    begin n_fail++; $display("FAIL rst_busy80: got %b required 0", b80); end
        if (dn80 !== 1'b0)   begin n_fail++; $display("FAIL rst_done80: got %b required 0", dn80); end
        if (q80 !== 64'h0)   begin n_fail++; $display("FAIL rst_data80: got %h required 0", q80); end
        if (r128 !== 1'b1)   begin n_fail++; $display("FAIL rst_ready128: got %b required 1", r128); end
        if (b128 !== 1'b0)   begin n_fail++; $display("FAIL rst_busy128: got %b required 0", b128); end
        if (dn128 !== 1'b0)  begin n_fail++; $display("FAIL rst_done128: got %b required 0", dn128); end
        if (q128 !== 64'h0)  begin n_fail++; $display("FAIL rst_data128: got %h required 0", q128); end
    endtask

    task automatic test_encrypt80();
        issue(0, 1'b0, '0, 64'h0, 64'h5579C1387B228445, 32, 1);
        sb_collect("enc80_k0");
    endtask

    task automatic test_cold_decrypt80();
        pulse_reset();
        issue(0, 1'b1, ONES, 64'hE72C46C0F5945049, 64'h0, 63, 1);
        sb_collect("dec80_cold");
    endtask

    task automatic test_enc_dec80();
        issue(0, 1'b0, ONES, 64'hFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2, 32, 1);
        sb_collect("enc80_k1");
        issue(0, 1'b1, ONES, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, HIT_LAT, 1);
        sb_collect("dec80_cached");
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        issue(0, 1'b1, ONES, 64'h3333DCD3213210D2, 64'h0, 0, 0);
        repeat (10) begin @(posedge clk); #1; if (dn80) seen = 1'b1; end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (70) begin @(posedge clk); #1; if (dn80) seen = 1'b1; end
        n_checks += 3;
        if (seen !== 1'b0)  begin n_fail++; $display("FAIL abort_no_done: done seen=%b required 0", seen); end
        if (r80 !== 1'b1)   begin n_fail++; $display("FAIL abort_ready: got %b required 1", r80); end
        if (q80 !== 64'h0)  begin n_fail++; $display("FAIL abort_data: got %h required 0", q80); end
        // Cache must be cold again after the reset.
        issue(0, 1'b1, ONES, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, 63, 1);
        sb_collect("dec80_after_rst");
        issue(0, 1'b0, '0, 64'hFFFFFFFFFFFFFFFF, 64'hA112FFC72F68417B, 32, 1);
        sb_collect("enc80_after_rst");
    endtask

    task automatic test_key128();
        issue(1, 1'b0, '0, 64'h0, 64'h96DB702A2E6900AF, 32, 1);
        sb_collect("enc128");
        issue(1, 1'b1, '0, 64'h96DB702A2E6900AF, 64'h0, HIT_LAT, 1);
        sb_collect("dec128");
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        while (!r80 && n < 200) begin @(posedge clk); #1; n++; end
        drive(0, 1'b1, 1'b0, '0, 64'h0);
        @(posedge clk); #1;
        push_exp(0, 64'h5579C1387B228445, 32);
        drive(0, 1'b1, 1'b1, ONES, 64'hE72C46C0F5945049);
        sb_collect("b2b_enc");
        @(posedge clk); #1;
        push_exp(0, 64'h0, 63);
        n_checks++;
        if (b80 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy=%b required 1", b80); end
        sb_collect("b2b_dec_miss");
        drive(0, 1'b0, 1'b0, '0, 64'h0);
        @(posedge clk); #1;
        n_checks++;
        if (r80 !== 1'b1 || dn80 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: ready=%b done=%b required 1/0", r80, dn80);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s80 = 1'b0; m80 = 1'b0; k80 = '0; d80 = '0;
        s128 = 1'b0; m128 = 1'b0; k128 = '0; d128 = '0;
        test_reset();
        test_encrypt80();
        test_cold_decrypt80();
        test_enc_dec80();
        test_reset_mid();
        test_key128();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
